// File: rtl/seq_det4.sv
// seq_det4: detects the four-symbol pattern P0,P1,P2,P3 in a valid-qualified
// symbol stream. It produces a registered one-cycle detect pulse per match,
// a saturating 8-bit match counter with a synchronous clear, and exposes the
// FSM state for debug.
// Optional feature macro: SEQ_DET_OVERLAP_EN -- when defined, the symbol that
// completes a match may also start the next pattern (only possible if P3==P0).
module seq_det4 #(
    parameter int WIDTH = 3,
    parameter int P0    = 4,
    parameter int P1    = 2,
    parameter int P2    = 3,
    parameter int P3    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clr,
    output logic             detect,
    output logic [7:0]       match_cnt,
    output logic [1:0]       state
);

    // Pattern symbols truncated to the symbol width so every comparison
    // covers exactly WIDTH bits.
    localparam logic [WIDTH-1:0] L_P0 = WIDTH'(P0);
    localparam logic [WIDTH-1:0] L_P1 = WIDTH'(P1);
    localparam logic [WIDTH-1:0] L_P2 = WIDTH'(P2);
    localparam logic [WIDTH-1:0] L_P3 = WIDTH'(P3);

    // Progress through the pattern: number of leading symbols already seen.
    localparam logic [1:0] S0 = 2'd0;
    localparam logic [1:0] S1 = 2'd1;
    localparam logic [1:0] S2 = 2'd2;
    localparam logic [1:0] S3 = 2'd3;

    logic [1:0]       r_state;
    logic             r_detect;
    logic [7:0]       r_match_cnt;

    logic [1:0]       w_next_state;
    logic             w_accept;
    logic [WIDTH-1:0] w_expected;
    logic             w_is_p0;
    logic [1:0]       w_restart_state;
    logic [1:0]       w_after_match_state;

    // Symbol the current state is waiting for (S3 is handled separately).
    always_comb begin
        w_expected = L_P0;
        case (r_state)
            S0:      w_expected = L_P0;
            S1:      w_expected = L_P1;
            S2:      w_expected = L_P2;
            default: w_expected = L_P3;
        endcase
    end

    // Where to go on a mismatch: the offending symbol may itself start a pattern.
    assign w_is_p0         = (in_data == L_P0);
    assign w_restart_state = w_is_p0 ? S1 : S0;

`ifdef SEQ_DET_OVERLAP_EN
    // The completing symbol is allowed to be the first symbol of the next pattern.
    assign w_after_match_state = w_restart_state;
`else
    // The completing symbol is consumed by the match and never reused.
    assign w_after_match_state = S0;
`endif

    // Next-state and match-accept decode; nothing moves without in_valid.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        if (in_valid) begin
            if (r_state == S3 && in_data == L_P3) begin
                w_accept     = 1'b1;
                w_next_state = w_after_match_state;
            end else if (r_state != S3 && in_data == w_expected) begin
                w_next_state = r_state + 2'd1;
            end else begin
                w_next_state = w_restart_state;
            end
        end
    end

    // FSM state and registered detect pulse; clr deliberately has no effect here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S0;
            r_detect <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_detect <= w_accept;
        end
    end

    // Saturating match counter; clr wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_match_cnt <= 8'd0;
        end else if (clr) begin
            r_match_cnt <= 8'd0;
        end else if (w_accept && r_match_cnt != 8'hFF) begin
            r_match_cnt <= r_match_cnt + 8'd1;
        end
    end

    assign detect    = r_detect;
    assign match_cnt = r_match_cnt;
    assign state     = r_state;

endmodule

// File: tb/tb_seq_det4.sv
// tb_seq_det4: self-checking bench for seq_det4 (default parameters).
// A behavioural model tracks pattern progress as an index into a symbol
// array and is compared with the DUT after every clock edge; directed
// scenarios additionally pin results to hand-computed literal values,
// followed by a randomized stream.
module tb_seq_det4;

    localparam int WIDTH = 3;

`ifdef SEQ_DET_OVERLAP_EN
    localparam bit OVERLAP = 1'b1;
`else
    localparam bit OVERLAP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             clr = 1'b0;
    logic             detect;
    logic [7:0]       match_cnt;
    logic [1:0]       state;

    int checks = 0;
    int errors = 0;

    seq_det4 #(.WIDTH(WIDTH), .P0(4), .P1(2), .P2(3), .P3(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .clr       (clr),
        .detect    (detect),
        .match_cnt (match_cnt),
        .state     (state)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int pat [4] = '{4, 2, 3, 4};
    int m_prog = 0;
    int m_det  = 0;
    int m_cnt  = 0;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // Model update on each rising edge, then compare with the DUT shortly after.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_prog = 0;
                m_det  = 0;
                m_cnt  = 0;
            end else begin
                m_det = 0;
                if (in_valid) begin
                    if (m_prog == 3 && int'(in_data) == pat[3]) begin
                        m_det = 1;
                        if (m_cnt < 255) m_cnt = m_cnt + 1;
                        m_prog = (OVERLAP && int'(in_data) == pat[0]) ? 1 : 0;
                    end else if (m_prog < 3 && int'(in_data) == pat[m_prog]) begin
                        m_prog = m_prog + 1;
                    end else begin
                        m_prog = (int'(in_data) == pat[0]) ? 1 : 0;
                    end
                end
                if (clr) m_cnt = 0;
            end
            #1;
            check("model_state", int'(state), m_prog);
            check("model_detect", int'(detect), m_det);
            check("model_cnt", int'(match_cnt), m_cnt);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drv(input bit v, input int d, input bit c, input bit r);
        @(negedge clk);
        in_valid = v;
        in_data  = WIDTH'(d);
        clr      = c;
        rst_n    = r;
    endtask

    task automatic sym(input int d);
        drv(1'b1, d, 1'b0, 1'b1);
    endtask

    task automatic idle();
        drv(1'b0, 0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        drv(1'b0, 0, 1'b0, 1'b0);
        drv(1'b0, 0, 1'b0, 1'b0);
    endtask

    // Wait until just after the edge that consumes the last driven inputs.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    localparam int EXP_OVL = OVERLAP ? 2 : 1;

    initial begin
        // Reset state
        do_reset();
        settle();
        $display("txn reset: state=%0d detect=%0d cnt=%0d", state, detect, match_cnt);
        check("reset_state", int'(state), 0);
        check("reset_detect", int'(detect), 0);
        check("reset_cnt", int'(match_cnt), 0);

        // Reset held while a full valid pattern streams in
        drv(1'b1, 4, 1'b1, 1'b0);
        drv(1'b1, 2, 1'b0, 1'b0);
        drv(1'b1, 3, 1'b0, 1'b0);
        drv(1'b1, 4, 1'b0, 1'b0);
        settle();
        $display("txn reset_held: state=%0d detect=%0d cnt=%0d", state, detect, match_cnt);
        check("held_state", int'(state), 0);
        check("held_detect", int'(detect), 0);
        check("held_cnt", int'(match_cnt), 0);

        // Basic match: pulse right after the fourth symbol, then low again
        do_reset();
        sym(4); sym(2); sym(3); sym(4);
        settle();
        $display("txn basic: detect=%0d cnt=%0d", detect, match_cnt);
        check("basic_detect", int'(detect), 1);
        check("basic_cnt", int'(match_cnt), 1);
        idle();
        settle();
        check("basic_pulse_end", int'(detect), 0);

        // Overlap behaviour
        do_reset();
        sym(4); sym(2); sym(3); sym(4); sym(2); sym(3); sym(4);
        idle();
        settle();
        $display("txn overlap: cnt=%0d", match_cnt);
        check("overlap_cnt", int'(match_cnt), EXP_OVL);

        // Gap in the middle of a pattern holds state
        do_reset();
        sym(4); sym(2);
        idle(); idle(); idle();
        settle();
        check("gap_state", int'(state), 2);
        sym(3); sym(4);
        settle();
        $display("txn gap: detect=%0d cnt=%0d", detect, match_cnt);
        check("gap_detect", int'(detect), 1);
        check("gap_cnt", int'(match_cnt), 1);

        // Repeated P0 restarts at S1
        do_reset();
        sym(4); sym(4); sym(2); sym(3); sym(4);
        settle();
        $display("txn restart: detect=%0d cnt=%0d", detect, match_cnt);
        check("restart_cnt", int'(match_cnt), 1);

        // Broken pattern
        do_reset();
        sym(4); sym(2); sym(6); sym(3); sym(4);
        idle();
        settle();
        $display("txn broken: cnt=%0d", match_cnt);
        check("broken_cnt", int'(match_cnt), 0);

        // Reset mid-pattern discards progress
        do_reset();
        sym(4); sym(2); sym(3);
        drv(1'b0, 0, 1'b0, 1'b0);
        sym(4);
        idle();
        settle();
        $display("txn midreset: cnt=%0d state=%0d", match_cnt, state);
        check("midreset_cnt", int'(match_cnt), 0);
        check("midreset_state", int'(state), 1);

        // Saturation, then clr on the cycle of a match
        do_reset();
        for (int i = 0; i < 299; i++) begin
            sym(4); sym(2); sym(3); sym(4);
        end
        settle();
        $display("txn saturate: cnt=%0d", match_cnt);
        check("sat_cnt", int'(match_cnt), 255);
        sym(4); sym(2); sym(3);
        drv(1'b1, 4, 1'b1, 1'b1);
        settle();
        $display("txn clr_on_match: detect=%0d cnt=%0d", detect, match_cnt);
        check("clr_detect", int'(detect), 1);
        check("clr_cnt", int'(match_cnt), 0);

        // Randomized stream, biased toward pattern symbols
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int d;
            if ($urandom_range(0, 3) != 0) d = pat[$urandom_range(0, 3)];
            else d = int'($urandom_range(0, 7));
            drv($urandom_range(0, 9) < 8, d,
                $urandom_range(0, 49) == 0,
                $urandom_range(0, 99) != 0);
        end
        idle();
        settle();
        $display("txn random: done cnt=%0d", match_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
